// File: rtl/aes_shift_rows_if.sv
// Handshake bundle for the AES ShiftRows stage.
// The inv select only exists when AES_INV_SHIFT_ROWS_EN is defined.
interface aes_shift_rows_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
`ifdef AES_INV_SHIFT_ROWS_EN
    logic         inv;
`endif

    // Upstream/downstream side driving the block
    modport master (
        output in_valid, state_in, out_ready,
`ifdef AES_INV_SHIFT_ROWS_EN
        output inv,
`endif
        input  in_ready, out_valid, state_out
    );

    // The ShiftRows block itself
    modport slave (
        input  in_valid, state_in, out_ready,
`ifdef AES_INV_SHIFT_ROWS_EN
        input  inv,
`endif
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/aes_shift_rows.sv
// AES ShiftRows byte permutation with a valid/ready output stage.
// Byte k of the state is bits [127-8k -: 8]; s(r,c) = b[r+4c].
// Optional macro AES_INV_SHIFT_ROWS_EN adds an inv select for InvShiftRows.
// OUT_REG=1 registers the output (latency 1, full throughput);
// OUT_REG=0 is a combinational pass-through of data and handshake.
module aes_shift_rows #(
    parameter bit OUT_REG = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    aes_shift_rows_if.slave bus
);

    // Rows rotate left by r (forward) or right by r (inverse); pure wiring.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        int           src_c;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                src_c = inv ? ((col - row + 4) % 4) : ((col + row) % 4);
                r[127 - 8*(row + 4*col) -: 8] = s[127 - 8*(row + 4*src_c) -: 8];
            end
        end
        return r;
    endfunction

    logic         inv_sel;
    logic [127:0] perm;

`ifdef AES_INV_SHIFT_ROWS_EN
    assign inv_sel = bus.inv;
`else
    assign inv_sel = 1'b0;
`endif

    assign perm = shift_rows(bus.state_in, inv_sel);

    generate
        if (OUT_REG) begin : g_reg
            logic         out_valid_q;
            logic [127:0] state_q;
            logic         in_fire;

            // A free slot exists when empty or when the held state leaves now
            assign bus.in_ready  = !out_valid_q || bus.out_ready;
            assign in_fire       = bus.in_valid && bus.in_ready;
            assign bus.out_valid = out_valid_q;
            assign bus.state_out = state_q;

            // Output register: reload on input transfer, drain on output transfer
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    state_q     <= '0;
                end else if (in_fire) begin
                    out_valid_q <= 1'b1;
                    state_q     <= perm;
                end else if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end else begin : g_comb
            assign bus.in_ready  = bus.out_ready;
            assign bus.out_valid = bus.in_valid;
            assign bus.state_out = perm;
        end
    endgenerate

endmodule

// File: tb/tb_aes_shift_rows.sv
// Self-checking bench for aes_shift_rows (OUT_REG=1) with a queue scoreboard.
// Inverse tests are compiled in when AES_INV_SHIFT_ROWS_EN is defined.
module tb_aes_shift_rows;

    logic clk;
    logic rst_n;
    aes_shift_rows_if bus ();

    aes_shift_rows #(.OUT_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] exp_q[$];
    logic         tb_inv;

    // Observations captured on the falling edge
    logic         o_fire, o_vld, o_rdy;
    logic [127:0] o_state;

    // Forward mapping as a table: output byte k takes input byte fwd_map[k]
    int fwd_map[16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    // Forward gathers from the table; inverse scatters through the same table
    function automatic logic [127:0] ref_perm(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (!inv) r[127 - 8*k -: 8] = s[127 - 8*fwd_map[k] -: 8];
            else      r[127 - 8*fwd_map[k] -: 8] = s[127 - 8*k -: 8];
        end
        return r;
    endfunction

    // Advance one clock: sample at negedge, log input transfers to the scoreboard
    task automatic cycle();
        @(negedge clk);
        o_vld   = bus.out_valid;
        o_rdy   = bus.in_ready;
        o_fire  = bus.out_valid && bus.out_ready;
        o_state = bus.state_out;
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
            exp_q.push_back(ref_perm(bus.state_in, tb_inv));
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [127:0] s, input logic inv);
        bus.in_valid = v;
        bus.state_in = s;
        tb_inv       = inv;
`ifdef AES_INV_SHIFT_ROWS_EN
        bus.inv      = inv;
`endif
    endtask

    task automatic test_reset();
        logic [127:0] a;
        a = 128'h0123456789abcdef0123456789abcdef;
        rst_n = 1'b0;
        set_in(1'b0, '0, 1'b0);
        bus.out_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // load a state and hold it, then reset mid-stream
        set_in(1'b1, a, 1'b0);
        cycle();
        set_in(1'b0, '0, 1'b0);
        cycle();
        n_total++;
        if (o_vld !== 1'b1) $display("FAIL reset_preload_valid: got %b expected 1", o_vld);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_async_valid: got %b expected 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.state_out !== 128'h0) $display("FAIL reset_async_state: got %h expected 0", bus.state_out);
        else n_pass++;
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        // X data with in_valid low must not raise out_valid
        bus.out_ready = 1'b1;
        set_in(1'b0, 'x, 1'b0);
        cycle();
        cycle();
        n_total++;
        if (o_vld !== 1'b0) $display("FAIL x_data_idle_valid: got %b expected 0", o_vld);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic [127:0] vin [3];
        logic [127:0] vexp[3];
        logic [127:0] e;
        vin[0] = 128'h0123456789abcdef0123456789abcdef; vexp[0] = 128'h01ab45ef8923cd6701ab45ef8923cd67;
        vin[1] = 128'hffeeddccbbaa99887766554433221100; vexp[1] = 128'hffaa5500bb6611cc7722dd8833ee9944;
        vin[2] = 128'h0;                                vexp[2] = 128'h0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, vin[i], 1'b0);
            cycle();
            set_in(1'b0, '0, 1'b0);
            cycle();
            n_total++;
            if (o_fire !== 1'b1) $display("FAIL vec%0d_valid: got %b expected 1", i, o_fire);
            else n_pass++;
            n_total++;
            if (o_state !== vexp[i]) $display("FAIL vec%0d_state: got %h expected %h", i, o_state, vexp[i]);
            else n_pass++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_total++;
            if (o_state !== e) $display("FAIL vec%0d_model: got %h expected %h", i, o_state, e);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, ea, e;
        a  = 128'h0123456789abcdef0123456789abcdef;
        b  = 128'hffeeddccbbaa99887766554433221100;
        ea = 128'h01ab45ef8923cd6701ab45ef8923cd67;
        bus.out_ready = 1'b0;
        set_in(1'b1, a, 1'b0);
        cycle();
        set_in(1'b1, b, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_total++;
            if (o_rdy !== 1'b0 || o_vld !== 1'b1 || o_state !== ea)
                $display("FAIL stall%0d: got rdy=%b vld=%b %h expected rdy=0 vld=1 %h", i, o_rdy, o_vld, o_state, ea);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        cycle();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_total++;
        if (o_fire !== 1'b1 || o_state !== e || o_state !== ea)
            $display("FAIL bp_release_a: got fire=%b %h expected fire=1 %h", o_fire, o_state, ea);
        else n_pass++;
        set_in(1'b0, '0, 1'b0);
        cycle();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_total++;
        if (o_fire !== 1'b1 || o_state !== e || o_state !== 128'hffaa5500bb6611cc7722dd8833ee9944)
            $display("FAIL bp_then_b: got fire=%b %h expected fire=1 %h", o_fire, o_state, e);
        else n_pass++;
        cycle();
        n_total++;
        if (o_vld !== 1'b0 || exp_q.size() != 0)
            $display("FAIL bp_no_dup: got vld=%b pending=%0d expected vld=0 pending=0", o_vld, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        int n_out;
        int n_gap;
        n_out = 0;
        n_gap = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_in(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
            else       set_in(1'b0, '0, 1'b0);
            cycle();
            if (i >= 1 && i <= 8 && o_fire !== 1'b1) n_gap++;
            if (o_fire === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_out++;
                n_total++;
                if (o_state !== e) $display("FAIL b2b_data%0d: got %h expected %h", n_out, o_state, e);
                else n_pass++;
            end
        end
        n_total++;
        if (n_out != 8 || n_gap != 0)
            $display("FAIL b2b_throughput: got outputs=%0d gaps=%0d expected outputs=8 gaps=0", n_out, n_gap);
        else n_pass++;
    endtask

`ifdef AES_INV_SHIFT_ROWS_EN
    task automatic test_inv();
        logic [127:0] x, y, e;
        bus.out_ready = 1'b1;
        set_in(1'b1, 128'hffaa5500bb6611cc7722dd8833ee9944, 1'b1);
        cycle();
        set_in(1'b0, '0, 1'b0);
        cycle();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_total++;
        if (o_fire !== 1'b1 || o_state !== 128'hffeeddccbbaa99887766554433221100 || o_state !== e)
            $display("FAIL inv_vector: got %h expected ffeeddccbbaa99887766554433221100", o_state);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            set_in(1'b1, x, 1'b0);
            cycle();
            set_in(1'b0, '0, 1'b0);
            cycle();
            y = o_state;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            set_in(1'b1, y, 1'b1);
            cycle();
            set_in(1'b0, '0, 1'b0);
            cycle();
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            n_total++;
            if (o_fire !== 1'b1 || o_state !== x)
                $display("FAIL inv_roundtrip%0d: got %h expected %h", i, o_state, x);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        tb_inv = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
`ifdef AES_INV_SHIFT_ROWS_EN
        test_inv();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
